// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   D_WIDTH_DEF : default datapath width (matches `D_WIDTH in param.v)
//   PC_ADDR     : architectural register that is the program counter (r15)
//   LR_ADDR     : link register (r14)
//   rf_addr_t   : register-file address type
package rf_writeback_arbiter_pkg;

  localparam int         D_WIDTH_DEF = 32;
  localparam logic [3:0] PC_ADDR     = 4'hF;
  localparam logic [3:0] LR_ADDR     = 4'hE;

  typedef logic [3:0] rf_addr_t;

endpackage

// File: rtl/rf_wb_select.sv
// Combinational scan/grant logic for the writeback arbiter.
// Requesters are scanned in rotation order starting at rr_ptr, starved ones
// first, then the rest. Up to two register writes (distinct addresses) and one
// PC redirect are granted.
//   valid    : request valid per requester
//   addr     : 4-bit destination per requester, requester k at [4k+3:4k]
//   starved  : requester has waited the starvation limit
//   rr_ptr   : rotation start index
//   grant    : one bit per granted requester
//   wr1_*    : requester mapped to register write port 1
//   wr2_*    : requester mapped to register write port 2
//   pc_*     : requester mapped to the PC redirect slot
//   last_idx : last requester granted in scan order
module rf_wb_select
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]   valid,
  input  logic [4*N_REQ-1:0] addr,
  input  logic [N_REQ-1:0]   starved,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [N_REQ-1:0]   grant,
  output logic               wr1_vld,
  output logic [PTR_W-1:0]   wr1_idx,
  output logic               wr2_vld,
  output logic [PTR_W-1:0]   wr2_idx,
  output logic               pc_vld,
  output logic [PTR_W-1:0]   pc_idx,
  output logic [PTR_W-1:0]   last_idx
);

  always_comb begin
    int       k;
    logic     want;
    rf_addr_t a;
    rf_addr_t a1;
    grant    = '0;
    wr1_vld  = 1'b0;
    wr1_idx  = '0;
    wr2_vld  = 1'b0;
    wr2_idx  = '0;
    pc_vld   = 1'b0;
    pc_idx   = '0;
    last_idx = '0;
    k        = 0;
    want     = 1'b0;
    a        = '0;
    a1       = '0;
    // pass 0 visits only starved requesters, pass 1 the remaining ones
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < N_REQ; i++) begin
        k = int'(rr_ptr) + i;
        if (k >= N_REQ) k = k - N_REQ;
        want = valid[k] && (starved[k] == (pass == 0));
        a    = addr[4*k +: 4];
        if (want) begin
          if (a == PC_ADDR) begin
            if (!pc_vld) begin
              pc_vld   = 1'b1;
              pc_idx   = PTR_W'(k);
              grant[k] = 1'b1;
              last_idx = PTR_W'(k);
            end
          end else if (!wr1_vld) begin
            wr1_vld  = 1'b1;
            wr1_idx  = PTR_W'(k);
            a1       = a;
            grant[k] = 1'b1;
            last_idx = PTR_W'(k);
          end else if (!wr2_vld && (a != a1)) begin
            wr2_vld  = 1'b1;
            wr2_idx  = PTR_W'(k);
            grant[k] = 1'b1;
            last_idx = PTR_W'(k);
          end
        end
      end
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter. Shares the two register-file write ports
// and the PC redirect path among N_REQ valid/ready writeback sources.
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_flush         : blocks every grant in the current cycle
//   i_req_valid     : request valid per requester
//   i_req_addr      : destination register per requester, [4k+3:4k]
//   i_req_data      : write data per requester, slice k
//   o_req_ready     : combinational grant per requester
//   o_WE1/WA1/WD1   : registered register-file write port 1
//   o_WE2/WA2/WD2   : registered register-file write port 2
//   o_pc_we/o_pc_wd : registered PC redirect to fetch
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int D_WIDTH      = D_WIDTH_DEF,
  parameter int N_REQ        = 3,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [4*N_REQ-1:0]       i_req_addr,
  input  logic [D_WIDTH*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic                     o_WE1,
  output logic [3:0]               o_WA1,
  output logic [D_WIDTH-1:0]       o_WD1,
  output logic                     o_WE2,
  output logic [3:0]               o_WA2,
  output logic [D_WIDTH-1:0]       o_WD2,
  output logic                     o_pc_we,
  output logic [D_WIDTH-1:0]       o_pc_wd
);

  localparam int PTR_W = $clog2(N_REQ);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_W'(STARVE_LIMIT)) return CNT_W'(STARVE_LIMIT);
    return c + CNT_W'(1);
  endfunction

  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   cnt [N_REQ];
  logic [N_REQ-1:0]   starved;
  logic [N_REQ-1:0]   grant_sel;
  logic [N_REQ-1:0]   grant_p0;
  logic               wr1_sel, wr2_sel, pc_sel;
  logic [PTR_W-1:0]   wr1_idx, wr2_idx, pc_idx, last_idx;
  logic               wr1_vld_p0, wr2_vld_p0, pc_vld_p0;
  rf_addr_t           wa1_p0, wa2_p0;
  logic [D_WIDTH-1:0] wd1_p0, wd2_p0, pc_wd_p0;
  logic               wr1_vld_p1, wr2_vld_p1, pc_vld_p1;
  rf_addr_t           wa1_p1, wa2_p1;
  logic [D_WIDTH-1:0] wd1_p1, wd2_p1, pc_wd_p1;

  // ---- p0: combinational scan, grant and operand select ----
  always_comb begin
    for (int k = 0; k < N_REQ; k++) starved[k] = (cnt[k] == CNT_W'(STARVE_LIMIT));
  end

  rf_wb_select #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_select (
    .valid    (i_req_valid),
    .addr     (i_req_addr),
    .starved  (starved),
    .rr_ptr   (rr_ptr),
    .grant    (grant_sel),
    .wr1_vld  (wr1_sel),
    .wr1_idx  (wr1_idx),
    .wr2_vld  (wr2_sel),
    .wr2_idx  (wr2_idx),
    .pc_vld   (pc_sel),
    .pc_idx   (pc_idx),
    .last_idx (last_idx)
  );

  always_comb begin
    grant_p0   = i_flush ? '0 : grant_sel;
    wr1_vld_p0 = wr1_sel && !i_flush;
    wr2_vld_p0 = wr2_sel && !i_flush;
    pc_vld_p0  = pc_sel && !i_flush;
    wa1_p0     = i_req_addr[int'(wr1_idx)*4 +: 4];
    wa2_p0     = i_req_addr[int'(wr2_idx)*4 +: 4];
    wd1_p0     = i_req_data[int'(wr1_idx)*D_WIDTH +: D_WIDTH];
    wd2_p0     = i_req_data[int'(wr2_idx)*D_WIDTH +: D_WIDTH];
    pc_wd_p0   = i_req_data[int'(pc_idx)*D_WIDTH +: D_WIDTH];
    // counters sit at zero in reset, so ready must be masked explicitly
    o_req_ready = rst_n ? grant_p0 : '0;
  end

  // ---- p1: arbitration state and registered write ports ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      wr1_vld_p1 <= 1'b0;
      wr2_vld_p1 <= 1'b0;
      pc_vld_p1  <= 1'b0;
      wa1_p1     <= '0;
      wa2_p1     <= '0;
      wd1_p1     <= '0;
      wd2_p1     <= '0;
      pc_wd_p1   <= '0;
      for (int k = 0; k < N_REQ; k++) cnt[k] <= '0;
    end else begin
      wr1_vld_p1 <= wr1_vld_p0;
      wr2_vld_p1 <= wr2_vld_p0;
      pc_vld_p1  <= pc_vld_p0;
      if (wr1_vld_p0) begin
        wa1_p1 <= wa1_p0;
        wd1_p1 <= wd1_p0;
      end
      if (wr2_vld_p0) begin
        wa2_p1 <= wa2_p0;
        wd2_p1 <= wd2_p0;
      end
      if (pc_vld_p0) pc_wd_p1 <= pc_wd_p0;
      if (|grant_p0) begin
        rr_ptr <= (last_idx == PTR_W'(N_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
      end
      for (int k = 0; k < N_REQ; k++) begin
        if (i_flush || !i_req_valid[k] || grant_p0[k]) cnt[k] <= '0;
        else                                           cnt[k] <= sat_inc(cnt[k]);
      end
    end
  end

  assign o_WE1   = wr1_vld_p1;
  assign o_WA1   = wa1_p1;
  assign o_WD1   = wd1_p1;
  assign o_WE2   = wr2_vld_p1;
  assign o_WA2   = wa2_p1;
  assign o_WD2   = wd2_p1;
  assign o_pc_we = pc_vld_p1;
  assign o_pc_wd = pc_wd_p1;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Testbench for rf_writeback_arbiter: directed scenarios with literal
// expectations plus randomized valid/ready traffic against a behavioural model.
module tb_rf_writeback_arbiter;

  localparam int N   = 3;
  localparam int DW  = 32;
  localparam int LIM = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [4*N-1:0]  req_addr;
  logic [DW*N-1:0] req_data;
  logic [N-1:0]    o_req_ready;
  logic            o_WE1, o_WE2, o_pc_we;
  logic [3:0]      o_WA1, o_WA2;
  logic [DW-1:0]   o_WD1, o_WD2, o_pc_wd;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  int          m_rr;
  int          m_cnt [N];
  logic        m_we1, m_we2, m_pcwe;
  logic [3:0]  m_wa1, m_wa2;
  logic [31:0] m_wd1, m_wd2, m_pcwd;

  always #5 clk = ~clk;

  rf_writeback_arbiter #(
    .D_WIDTH      (DW),
    .N_REQ        (N),
    .STARVE_LIMIT (LIM),
    .CNT_W        (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (flush),
    .i_req_valid (req_valid),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_req_ready (o_req_ready),
    .o_WE1       (o_WE1),
    .o_WA1       (o_WA1),
    .o_WD1       (o_WD1),
    .o_WE2       (o_WE2),
    .o_WA2       (o_WA2),
    .o_WD2       (o_WD2),
    .o_pc_we     (o_pc_we),
    .o_pc_wd     (o_pc_wd)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, need 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    m_we1 = 0; m_we2 = 0; m_pcwe = 0;
    m_wa1 = 0; m_wa2 = 0; m_wd1 = 0; m_wd2 = 0; m_pcwd = 0;
  endtask

  // Build the visiting order as a list, then hand out slots from it.
  function automatic void model_grant(output logic [N-1:0] g, output int p1, output int p2,
                                      output int pc, output int last);
    int         order[$];
    logic [3:0] used[$];
    int         k;
    logic [3:0] a;
    bit         clash;
    g = '0; p1 = -1; p2 = -1; pc = -1; last = -1;
    for (int i = 0; i < N; i++) begin
      k = (m_rr + i) % N;
      if (req_valid[k] && m_cnt[k] == LIM) order.push_back(k);
    end
    for (int i = 0; i < N; i++) begin
      k = (m_rr + i) % N;
      if (req_valid[k] && m_cnt[k] != LIM) order.push_back(k);
    end
    if (flush) order.delete();
    for (int j = 0; j < order.size(); j++) begin
      k = order[j];
      a = req_addr[4*k +: 4];
      clash = 0;
      for (int u = 0; u < used.size(); u++) if (used[u] == a) clash = 1;
      if (a == 4'hF) begin
        if (pc < 0) begin pc = k; g[k] = 1'b1; last = k; end
      end else if (used.size() < 2 && !clash) begin
        if (p1 < 0) p1 = k; else p2 = k;
        used.push_back(a);
        g[k] = 1'b1;
        last = k;
      end
    end
  endfunction

  // Single compare process: checks every cycle at the falling edge.
  always @(negedge clk) begin : compare
    logic [N-1:0] g;
    int p1, p2, pc, last;
    if (!rst_n) model_reset();
    chk("WE1", o_WE1, m_we1);
    chk("WE2", o_WE2, m_we2);
    chk("PCWE", o_pc_we, m_pcwe);
    chk("WA1", o_WA1, m_wa1);
    chk("WA2", o_WA2, m_wa2);
    chk("WD1", o_WD1, m_wd1);
    chk("WD2", o_WD2, m_wd2);
    chk("PCWD", o_pc_wd, m_pcwd);
    if (!rst_n) begin
      chk("ready_in_reset", o_req_ready, '0);
    end else begin
      model_grant(g, p1, p2, pc, last);
      chk("ready", o_req_ready, g);
      m_we1 = (p1 >= 0);
      m_we2 = (p2 >= 0);
      m_pcwe = (pc >= 0);
      if (p1 >= 0) begin m_wa1 = req_addr[4*p1 +: 4]; m_wd1 = req_data[DW*p1 +: DW]; end
      if (p2 >= 0) begin m_wa2 = req_addr[4*p2 +: 4]; m_wd2 = req_data[DW*p2 +: DW]; end
      if (pc >= 0) m_pcwd = req_data[DW*pc +: DW];
      for (int k = 0; k < N; k++) begin
        if (flush || g[k] || !req_valid[k]) m_cnt[k] = 0;
        else if (m_cnt[k] < LIM)            m_cnt[k] = m_cnt[k] + 1;
      end
      if (last >= 0) m_rr = (last + 1) % N;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [3:0] a, input logic [31:0] d);
    req_valid[k]          = 1'b1;
    req_addr[4*k +: 4]    = a;
    req_data[DW*k +: DW]  = d;
  endtask

  // A lone grant to requester 2 leaves the rotation pointer at 0.
  task automatic solo2();
    req_valid = '0;
    set_req(2, 4'd9, 32'h99);
    step();
    req_valid = '0;
  endtask

  initial begin : stim
    logic [N-1:0] xfer;
    logic [2:0]   rot_exp [3];
    rot_exp = '{3'b011, 3'b101, 3'b110};
    rst_n = 1'b0; flush = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    set_req(0, 4'd3, 32'hAAAA5555);
    #12;
    chk("rst_ready", o_req_ready, 3'b000);
    chk("rst_we1", o_WE1, 1'b0);
    step();
    rst_n = 1'b1;

    // single write
    @(negedge clk); chk("single_ready", o_req_ready, 3'b001);
    step();
    chk("single_we1", o_WE1, 1'b1);
    chk("single_wa1", o_WA1, 4'd3);
    chk("single_wd1", o_WD1, 32'hAAAA5555);
    chk("single_we2", o_WE2, 1'b0);
    req_valid = '0;
    solo2();

    // dual write
    set_req(0, 4'd1, 32'h11); set_req(1, 4'd2, 32'h22);
    @(negedge clk); chk("dual_ready", o_req_ready, 3'b011);
    step();
    chk("dual_wa1", o_WA1, 4'd1); chk("dual_wd1", o_WD1, 32'h11);
    chk("dual_wa2", o_WA2, 4'd2); chk("dual_wd2", o_WD2, 32'h22);
    chk("dual_we2", o_WE2, 1'b1);
    req_valid = '0;
    solo2();

    // three-way contention, rotation from pointer 0
    set_req(0, 4'd4, 32'h44); set_req(1, 4'd5, 32'h55); set_req(2, 4'd6, 32'h66);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("rotate_ready", o_req_ready, rot_exp[c]);
      step();
    end
    req_valid = '0;

    // same-address conflict
    set_req(0, 4'd7, 32'h70); set_req(1, 4'd7, 32'h71);
    @(negedge clk); chk("conflict_ready0", o_req_ready, 3'b001);
    step();
    chk("conflict_wd1", o_WD1, 32'h70); chk("conflict_we2", o_WE2, 1'b0);
    req_valid[0] = 1'b0;
    @(negedge clk); chk("conflict_ready1", o_req_ready, 3'b010);
    step();
    chk("conflict_wd1b", o_WD1, 32'h71); chk("conflict_wa1b", o_WA1, 4'd7);
    req_valid = '0;
    solo2();

    // PC redirect alongside two writes, then two PC requests
    set_req(0, 4'hF, 32'h100); set_req(1, 4'd5, 32'h55); set_req(2, 4'd6, 32'h66);
    @(negedge clk); chk("pc_ready", o_req_ready, 3'b111);
    step();
    chk("pc_we", o_pc_we, 1'b1); chk("pc_wd", o_pc_wd, 32'h100);
    chk("pc_wa1", o_WA1, 4'd5); chk("pc_wa2", o_WA2, 4'd6);
    req_valid = '0;
    set_req(0, 4'hF, 32'h200); set_req(1, 4'hF, 32'h300);
    @(negedge clk); chk("pc2_ready", o_req_ready, 3'b001);
    step();
    chk("pc2_wd", o_pc_wd, 32'h200); chk("pc2_we1", o_WE1, 1'b0);
    req_valid[0] = 1'b0;
    @(negedge clk); chk("pc2_ready_b", o_req_ready, 3'b010);
    step();
    chk("pc2_wd_b", o_pc_wd, 32'h300);
    req_valid = '0;

    // flush
    set_req(0, 4'd3, 32'h33); flush = 1'b1;
    @(negedge clk); chk("flush_ready", o_req_ready, 3'b000);
    step();
    chk("flush_we1", o_WE1, 1'b0);
    flush = 1'b0;
    @(negedge clk); chk("post_flush_ready", o_req_ready, 3'b001);
    step();
    chk("post_flush_wd1", o_WD1, 32'h33);
    req_valid = '0;

    // reset mid-stream
    set_req(0, 4'd8, 32'h88); set_req(1, 4'd9, 32'h99);
    step();
    chk("pre_rst_we1", o_WE1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_we1", o_WE1, 1'b0); chk("async_rst_we2", o_WE2, 1'b0);
    chk("async_rst_wd1", o_WD1, 32'h0); chk("async_rst_wa2", o_WA2, 4'd0);
    chk("async_rst_pcwd", o_pc_wd, 32'h0); chk("async_rst_ready", o_req_ready, 3'b000);
    req_valid = '0;
    step(); step();
    rst_n = 1'b1;
    set_req(1, 4'd10, 32'hA1); set_req(2, 4'd10, 32'hA2);
    @(negedge clk); chk("post_rst_ready", o_req_ready, 3'b010);
    step();
    chk("post_rst_wd1", o_WD1, 32'hA1);
    req_valid = '0;

    // randomized traffic; valid/addr/data held until the transfer
    repeat (800) begin
      @(negedge clk);
      xfer = o_req_ready & req_valid;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (xfer[k]) req_valid[k] = 1'b0;
        if (!req_valid[k] && ($urandom_range(0, 9) < 7)) begin
          set_req(k, ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 5)), $urandom);
        end
      end
      flush = ($urandom_range(0, 19) == 0);
    end
    flush = 1'b0;
    req_valid = '0;
    step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Shares the register file's two write ports (WA1/WD1/WE1 and WA2/WD2/WE2) among N_REQ writeback sources: ALU0, ALU1 and LSU by default.
- Each source presents one result per cycle on a valid/ready handshake. Up to two register writes and one PC (r15) redirect are granted per cycle.
- Writes to address 15 never reach the register file. They are routed to a dedicated PC-redirect output for the fetch unit.
- Sits between the execute/memory stage outputs and register_file; registered outputs drive register_file and fetch directly.

Parameters:
- D_WIDTH, 32, data width; matches `D_WIDTH in param.v.
- N_REQ, 3, number of writeback requesters (2..8).
- STARVE_LIMIT, 4, wait cycles after which a requester gets top priority.
- CNT_W, 3, starvation counter width; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_flush  in  1  pipeline flush; blocks all grants this cycle.
- i_req_valid  in  N_REQ  request valid, one bit per requester.
- i_req_addr  in  4*N_REQ  destination register per requester; requester k uses bits [4k+3:4k].
- i_req_data  in  D_WIDTH*N_REQ  write data per requester; requester k uses slice k.
- o_req_ready  out  N_REQ  grant; the transfer happens when valid && ready.
- o_WE1, o_WA1[3:0], o_WD1[D_WIDTH-1:0]  out  register-file write port 1.
- o_WE2, o_WA2[3:0], o_WD2[D_WIDTH-1:0]  out  register-file write port 2.
- o_pc_we  out  1  PC redirect valid.
- o_pc_wd  out  D_WIDTH  PC redirect target.

Behaviour:
- Reset (async, rst_n=0):
  - o_WE1=o_WE2=o_pc_we=0; o_WA*=0, o_WD*=0, o_pc_wd=0.
  - rr_ptr=0; all starvation counters=0.
  - o_req_ready=0 while in reset.
- Handshake rules:
  - o_req_ready is combinational from i_req_valid, i_req_addr, rr_ptr, the counters and i_flush.
  - Requesters must not make valid depend on ready.
  - Once asserted, valid, addr and data are held until the transfer.
- Scan order each cycle:
  - Pass 1: requesters whose counter == STARVE_LIMIT, in rotation order starting at rr_ptr.
  - Pass 2: all remaining valid requesters, in the same rotation order.
- Grant rules (applied in scan order):
  - addr 0..14: granted if fewer than 2 register grants so far and addr differs from every register addr already granted this cycle. Otherwise the requester waits.
  - addr 15: granted if the PC slot is still free. It consumes no register port.
  - The first register grant maps to port 1, the second to port 2.
  - Ports are never granted the same address in one cycle; register_file's dual-write-same-address priority is never exercised.
- Latency: a grant in cycle t appears on o_WE/WA/WD and o_pc_* at the clk edge ending cycle t. It is visible to register_file in cycle t+1 and written at the end of t+1. Outputs deassert (WE=0) in any cycle without a grant; WA/WD hold their last value.
- rr_ptr: advances to (index of last granted requester in scan order + 1) mod N_REQ when any grant occurs; otherwise it holds.
- Starvation counter k:
  - Cleared on grant or when !valid.
  - Incremented when valid && !ready.
  - Saturates at STARVE_LIMIT.
- Flush: i_flush=1 forces o_req_ready=0. Next-cycle WE1/WE2/pc_we=0. Counters clear; rr_ptr holds.
- Same-address conflicts: if two valid requesters target the same register, the first in scan order wins and the other waits at least one cycle. Program order across requesters is the issue logic's responsibility.
- Reset mid-operation: pending requests are discarded and outputs clear immediately (async). No write leaks out after rst_n deasserts.

Decomposition:
- Shared package/param.v: D_WIDTH, PC_ADDR=4'hF, LR_ADDR=4'hE.
- One sub-module, rf_wb_select: purely combinational scan/grant logic taking the valid, addr, starved and rr_ptr vectors.
- The top level holds the registers: rr_ptr, counters, output flops.

Test Plan:
- Single write: after reset, req0 valid, addr=3, data=0xAAAA5555 → ready0=1 same cycle; next cycle o_WE1=1, o_WA1=3, o_WD1=0xAAAA5555, o_WE2=0.
- Dual write: req0 (addr 1, 0x11) and req1 (addr 2, 0x22), rr_ptr=0 → both ready; next cycle port1=(1,0x11), port2=(2,0x22); rr_ptr becomes 2.
- Three-way contention: all three valid with distinct addrs 4/5/6, held continuously → grants rotate 0,1 → 2,0 → 1,2. No requester waits more than 2 cycles.
- Same-address conflict: req0 and req1 both addr=7, rr_ptr=0 → only req0 granted, o_WE2=0; req1 granted the following cycle on port 1.
- PC redirect alongside writes: req0 addr=15 data=0x100, req1 addr=5, req2 addr=6 → all three ready; next cycle o_pc_we=1, o_pc_wd=0x100, port1=5, port2=6. Then two addr-15 requests in one cycle → only one is granted.
- Flush/reset: i_flush=1 with req0 valid → ready0=0 and WE1=0 next cycle. Assert rst_n=0 mid-stream → all outputs 0 immediately; after release, first grant follows rr_ptr=0.
